// File: rtl/voice_blk_serializer.sv
// Block-to-byte serializer: 128-bit blocks into a ring of 16-byte slots, streamed MSB byte first; 1-cycle write-to-read.
// in_ready = !full, out_valid = !empty (registered level); optional out_last port under `BLKBUF_LAST_EN.
module voice_blk_serializer #(
  parameter int SLOT_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [127:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef BLKBUF_LAST_EN
  output logic                 out_last,
`endif
  output logic [SLOT_LOG2:0]   level
);

  localparam int NSLOT = 1 << SLOT_LOG2;
  localparam logic [SLOT_LOG2:0] FULL_LVL = (SLOT_LOG2+1)'(NSLOT);

  logic [127:0]         mem_q [NSLOT];
  logic [127:0]         mem_d [NSLOT];
  logic [SLOT_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [SLOT_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]           rd_byte_q, rd_byte_d;
  logic [SLOT_LOG2:0]   level_q, level_d;

  logic                 full, empty;
  logic                 wr_fire, rd_fire, slot_free;
  logic [127:0]         rd_slot;
  logic [6:0]           bit_lo;

  always_comb begin
    full      = (level_q == FULL_LVL);
    empty     = (level_q == '0);
    wr_fire   = in_valid && !full;
    rd_fire   = !empty && out_ready;
    slot_free = rd_fire && (rd_byte_q == 4'd15);

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_byte_d = rd_byte_q;
    level_d   = level_q;

    if (wr_fire) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + SLOT_LOG2'(1);
    end

    // rd_byte wraps 15 -> 0 on its own as the slot is released
    if (rd_fire) begin
      rd_byte_d = rd_byte_q + 4'd1;
      if (slot_free) begin
        rd_ptr_d = rd_ptr_q + SLOT_LOG2'(1);
      end
    end

    case ({wr_fire, slot_free})
      2'b10:   level_d = level_q + (SLOT_LOG2+1)'(1);
      2'b01:   level_d = level_q - (SLOT_LOG2+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Byte k sits at bits [127-8k -: 8]; for 4-bit k, 15-k is just ~k.
  always_comb begin
    rd_slot  = mem_q[rd_ptr_q];
    bit_lo   = {~rd_byte_q, 3'b000};
    out_data = rd_slot[bit_lo +: 8];
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = level_q;
`ifdef BLKBUF_LAST_EN
  assign out_last  = !empty && (rd_byte_q == 4'd15);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_byte_q <= '0;
      level_q   <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_byte_q <= rd_byte_d;
      level_q   <= level_d;
    end
  end

endmodule

// File: tb/tb_voice_blk_serializer.sv
// Directed bench for voice_blk_serializer; block b carries byte value b*16+k at byte position k.
module tb_voice_blk_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   level;
`ifdef BLKBUF_LAST_EN
  logic         out_last;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  voice_blk_serializer #(.SLOT_LOG2(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BLKBUF_LAST_EN
    .out_last  (out_last),
`endif
    .level     (level)
  );

  function automatic logic [127:0] blk(input int b);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = 8'(b*16 + k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 3'd0 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b level=%0d out_data=%h, want 0 1 0 00",
               out_valid, in_ready, level, out_data);
    end
  endtask

  task automatic test_single();
    in_data = blk(0); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'(k) || level !== 3'd1) begin
        tests_failed++;
        $display("FAIL single_byte%0d: out_valid=%b out_data=%h level=%0d, want 1 %h 1",
                 k, out_valid, out_data, level, 8'(k));
      end
`ifdef BLKBUF_LAST_EN
      tests_run++;
      if (out_last !== (k == 15)) begin
        tests_failed++;
        $display("FAIL single_last%0d: out_last=%b want %b", k, out_last, (k == 15));
      end
`endif
      step();
    end
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_drained: out_valid=%b level=%0d, want 0 0", out_valid, level);
    end
`ifdef BLKBUF_LAST_EN
    tests_run++;
    if (out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_last_empty: out_last=%b want 0", out_last);
    end
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      tests_run++;
      if (in_ready !== 1'b1 || level !== 3'(b - 1)) begin
        tests_failed++;
        $display("FAIL fill_pre%0d: in_ready=%b level=%0d, want 1 %0d", b, in_ready, level, b - 1);
      end
      in_data = blk(b); in_valid = 1'b1;
      step();
    end
    tests_run++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_full: level=%0d in_ready=%b, want 4 0", level, in_ready);
    end
    in_data = blk(9);
    repeat (3) step();
    tests_run++;
    if (level !== 3'd4 || in_ready !== 1'b0 || out_data !== 8'h10 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_hold: level=%0d in_ready=%b out_data=%h out_valid=%b, want 4 0 10 1",
               level, in_ready, out_data, out_valid);
    end
  endtask

  task automatic test_full_free();
    in_data = blk(5); in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_data !== 8'(16 + k) || level !== 3'd4) begin
        tests_failed++;
        $display("FAIL full_free_byte%0d: in_ready=%b out_data=%h level=%0d, want 0 %h 4",
                 k, in_ready, out_data, level, 8'(16 + k));
      end
      step();
    end
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || level !== 3'd3) begin
      tests_failed++;
      $display("FAIL full_free_next: in_ready=%b level=%0d, want 1 3", in_ready, level);
    end
    step();
    in_valid = 1'b0;
    tests_run++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_free_refill: level=%0d in_ready=%b, want 4 0", level, in_ready);
    end
    // Slots 1..3 hold blocks 2..4; block 5 must come out of slot 0 last.
    out_ready = 1'b1;
    for (int b = 2; b <= 5; b++) begin
      for (int k = 0; k < 16; k++) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'(b*16 + k)) begin
          tests_failed++;
          $display("FAIL drain_b%0d_k%0d: out_valid=%b out_data=%h, want 1 %h",
                   b, k, out_valid, out_data, 8'(b*16 + k));
        end
        step();
      end
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      tests_failed++;
      $display("FAIL drain_empty: out_valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_wrap();
    int cnt;
    int pcyc;
    int ccyc;
    cnt = 0;
    fork
      begin
        pcyc = 0;
        for (int b = 0; b < 10; b++) begin
          logic acc;
          in_data = blk(b); in_valid = 1'b1;
          acc = 1'b0;
          while (!acc && pcyc < 3000) begin
            acc = in_ready;
            step();
            pcyc++;
          end
        end
        in_valid = 1'b0;
      end
      begin
        ccyc = 0;
        while (cnt < 160 && ccyc < 3000) begin
          out_ready = 1'($urandom_range(0, 1));
`ifdef BLKBUF_LAST_EN
          tests_run++;
          if (out_last !== (out_valid && (cnt % 16 == 15))) begin
            tests_failed++;
            $display("FAIL wrap_last%0d: out_last=%b out_valid=%b", cnt, out_last, out_valid);
          end
`endif
          if (out_valid && out_ready) begin
            tests_run++;
            if (out_data !== 8'(cnt)) begin
              tests_failed++;
              $display("FAIL wrap_byte%0d: out_data=%h want %h", cnt, out_data, 8'(cnt));
            end
            cnt++;
          end
          step();
          ccyc++;
        end
        out_ready = 1'b0;
      end
    join
    tests_run++;
    if (cnt !== 160 || out_valid !== 1'b0 || level !== 3'd0) begin
      tests_failed++;
      $display("FAIL wrap_total: bytes=%0d out_valid=%b level=%0d, want 160 0 0", cnt, out_valid, level);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int b = 10; b <= 12; b++) begin
      in_data = blk(b); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (7) step();
    out_ready = 1'b0;
    tests_run++;
    if (level !== 3'd3 || out_data !== 8'hA7) begin
      tests_failed++;
      $display("FAIL mid_setup: level=%0d out_data=%h, want 3 a7", level, out_data);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset: out_valid=%b level=%0d out_data=%h in_ready=%b, want 0 0 00 1",
               out_valid, level, out_data, in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    in_data = blk(13); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'(208 + k)) begin
        tests_failed++;
        $display("FAIL mid_restream%0d: out_valid=%b out_data=%h, want 1 %h",
                 k, out_valid, out_data, 8'(208 + k));
      end
      step();
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      tests_failed++;
      $display("FAIL mid_end: out_valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_free();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/voice_blk_serializer.md
# voice_blk_serializer

Block-to-byte serializer for the voice path. Accepts 128-bit blocks (16 bytes) over a valid/ready handshake and stores them in a small ring of 16-byte slots. It then streams the stored bytes out one per handshake, most-significant byte first. It is the write-side counterpart of the block reader that assembles 128-bit words from a byte memory, and feeds byte-wide voice sinks.

## Interface
- SLOT_LOG2, default 2: log2 of the slot count. Storage is (2^SLOT_LOG2)×16 bytes, held in flops.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  128  block; byte 0 = in_data[127:120], byte 15 = in_data[7:0].
- in_valid  input  1  in_data valid.
- in_ready  output  1  slot free; equals !full.
- out_data  output  8  current byte.
- out_valid  output  1  byte available; equals !empty.
- out_ready  input  1  sink accepts byte.
- level  output  SLOT_LOG2+1  number of occupied slots, 0..2^SLOT_LOG2.

## Operation
- State: wr_ptr and rd_ptr (SLOT_LOG2 bits, wrap modulo slot count), rd_byte (4 bits), level.
- Write: when in_valid && in_ready, all 16 bytes of in_data go to slot wr_ptr (byte k → mem[wr_ptr*16+k]), then wr_ptr+1.
- Read: out_data = mem[rd_ptr*16+rd_byte], driven combinationally from storage. When out_valid && out_ready, rd_byte+1.
  - On the transfer with rd_byte==15: rd_byte→0, rd_ptr+1, and the slot is freed.
- level: +1 on write only; −1 on slot-free only; unchanged when both happen in the same cycle.
- full = (level == 2^SLOT_LOG2); empty = (level == 0). Both derive from the registered level.
- Full with a slot freeing this cycle: in_ready stays 0 for that cycle. No same-cycle pass-through; the write is accepted next cycle.
- Empty: out_valid=0. out_ready is ignored and rd_byte does not advance.
- in_valid while full: no write, nothing corrupted. The upstream must hold in_data until in_ready.
- Partially read slot: no write can ever target it while it is being read, because level counts it as occupied until byte 15 transfers.
- Pointer wrap: slot 2^SLOT_LOG2−1 is followed by slot 0, on both sides.
- Arithmetic: pointers wrap naturally at SLOT_LOG2 bits. level must never exceed 2^SLOT_LOG2 or underflow below 0.

## Timing
- Reset (async assert, removed synchronously to clk):
  - wr_ptr = rd_ptr = rd_byte = 0, level = 0.
  - All storage bytes = 0, so out_data = 0.
  - out_valid = 0, in_ready = 1.
- Reset mid-stream discards all stored and partially read blocks immediately. There is no resume.
- Write-to-read latency: a block written at edge N gives out_valid=1 and out_data = byte 0 in the cycle after edge N.
- Throughput: one byte per cycle with out_ready held high. One block every 16 cycles sustains a full stream.
- in_ready, out_valid and level change only on clk edges or on reset.

## Configuration
- BLKBUF_LAST_EN defined:
  - Adds output port out_last (1 bit) = out_valid && (rd_byte == 15), marking the final byte of each block.
  - Reset value is 0.
- BLKBUF_LAST_EN undefined: port out_last and its logic are absent. All other behaviour is identical.

## Test plan
- Reset → single write: in_data = 128'h000102…0E0F, out_ready = 1.
  - Required: out_data sequence 0x00..0x0F on 16 consecutive cycles starting the cycle after the write.
  - Required: level 1 then 0; out_valid drops after byte 0x0F.
- Fill: 4 writes with out_ready = 0.
  - Required: level reaches 4, then in_ready = 0.
  - A 5th in_valid is held off; stored data is unchanged.
- Full plus free: full, read to byte 15 with in_valid = 1 throughout.
  - Required: in_ready is 0 on the free cycle, 1 the next cycle.
  - Required: the write is accepted there, level stays 4, and the new block goes to slot 0.
- Wrap: 10 blocks, block b holding byte value b*16+k, random out_ready.
  - Required: 160 bytes emerge in order with no loss or duplication.
- Async reset asserted mid-block at rd_byte = 7 with level = 3.
  - Required: out_valid = 0 and level = 0 immediately; out_data = 0.
  - Required: the next write streams from byte 0.
- With BLKBUF_LAST_EN defined: out_last pulses exactly on byte 15 of each block, and is 0 on all other bytes and while empty.
